// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage ahead of the integer ALU.
// Register file with writeback bypass, RAW/WAW scoreboard and a one-entry issue register.
module decode_issue #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rsn_i,
    input  logic            fetch_valid_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    input  logic [31:0]     fetch_instr_i,
    output logic            fetch_ready_o,
    output logic            alu_valid_o,
    input  logic            alu_ready_i,
    output logic [XLEN-1:0] alu_pc_o,
    output logic [31:0]     alu_instr_o,
    output logic [XLEN-1:0] alu_data_a_o,
    output logic [XLEN-1:0] alu_data_b_o,
    output logic [4:0]      alu_rd_o,
    output logic            alu_wb_en_o,
    output logic            alu_illegal_o,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [XLEN-1:0]  rf_r [NREGS];
    logic [NREGS-1:0] pending_r;
    logic [NREGS-1:0] pending_nxt_s;
    logic [NREGS-1:0] set_vec_s;
    logic [NREGS-1:0] clr_vec_s;

    logic             alu_valid_r;
    logic [XLEN-1:0]  alu_pc_r;
    logic [31:0]      alu_instr_r;
    logic [XLEN-1:0]  alu_data_a_r;
    logic [XLEN-1:0]  alu_data_b_r;
    logic [4:0]       alu_rd_r;
    logic             alu_wb_en_r;
    logic             alu_illegal_r;

    logic [6:0]       opcode_s;
    logic [4:0]       rs1_s;
    logic [4:0]       rs2_s;
    logic [4:0]       rd_s;
    logic             uses_rs1_s;
    logic             uses_rs2_s;
    logic             writes_rd_s;
    logic             illegal_s;
    logic             wb_en_s;
    logic             hazard_s;
    logic             fetch_ready_s;
    logic             accept_s;
    logic [XLEN-1:0]  data_a_s;
    logic [XLEN-1:0]  data_b_s;

    // A pending register stops being busy in the very cycle its writeback arrives.
    function automatic logic reg_busy(
        input logic [NREGS-1:0] pend,
        input logic [4:0]       r,
        input logic             wv,
        input logic [4:0]       wr
    );
        return pend[r] && !(wv && (wr == r));
    endfunction

    function automatic logic [XLEN-1:0] read_operand(
        input logic [4:0]      r,
        input logic [XLEN-1:0] rf_val,
        input logic            wv,
        input logic [4:0]      wr,
        input logic [XLEN-1:0] wd
    );
        logic [XLEN-1:0] val;
        if (r == 5'd0) begin
            val = '0;
        end else if (wv && (wr == r)) begin
            val = wd;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    assign opcode_s = fetch_instr_i[6:0];
    assign rs1_s    = fetch_instr_i[19:15];
    assign rs2_s    = fetch_instr_i[24:20];
    assign rd_s     = fetch_instr_i[11:7];

    // Opcode class decode
    always_comb begin
        uses_rs1_s  = 1'b0;
        uses_rs2_s  = 1'b0;
        writes_rd_s = 1'b0;
        illegal_s   = 1'b0;
        case (opcode_s)
            OP_REG: begin
                uses_rs1_s  = 1'b1;
                uses_rs2_s  = 1'b1;
                writes_rd_s = 1'b1;
            end
            OP_IMM, OP_LOAD: begin
                uses_rs1_s  = 1'b1;
                writes_rd_s = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
            end
            OP_SYSTEM: begin
                uses_rs1_s = 1'b1;
            end
            OP_JAL: begin
                writes_rd_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    assign wb_en_s = writes_rd_s && (rd_s != 5'd0);

    // Hazard detection, handshake and operand selection
    always_comb begin
        hazard_s = (uses_rs1_s  && reg_busy(pending_r, rs1_s, wb_valid_i, wb_rd_i)) ||
                   (uses_rs2_s  && reg_busy(pending_r, rs2_s, wb_valid_i, wb_rd_i)) ||
                   (writes_rd_s && reg_busy(pending_r, rd_s,  wb_valid_i, wb_rd_i));
        fetch_ready_s = !rsn_i && (!alu_valid_r || alu_ready_i) && !hazard_s && !flush_i;
        accept_s      = fetch_valid_i && fetch_ready_s;
        if (uses_rs1_s) begin
            data_a_s = read_operand(rs1_s, rf_r[rs1_s], wb_valid_i, wb_rd_i, wb_data_i);
        end else begin
            data_a_s = '0;
        end
        if (uses_rs2_s) begin
            data_b_s = read_operand(rs2_s, rf_r[rs2_s], wb_valid_i, wb_rd_i, wb_data_i);
        end else begin
            data_b_s = '0;
        end
    end

    // Scoreboard next state: a new issue to r wins over any clear of r in the same cycle
    always_comb begin
        set_vec_s = '0;
        clr_vec_s = '0;
        if (accept_s && wb_en_s) begin
            set_vec_s[rd_s] = 1'b1;
        end else begin
            set_vec_s = '0;
        end
        if (wb_valid_i && (wb_rd_i != 5'd0)) begin
            clr_vec_s[wb_rd_i] = 1'b1;
        end else begin
            clr_vec_s[0] = 1'b0;
        end
        if (flush_i && alu_valid_r && alu_wb_en_r) begin
            clr_vec_s[alu_rd_r] = 1'b1;
        end else begin
            clr_vec_s[0] = 1'b0;
        end
        pending_nxt_s    = (pending_r & ~clr_vec_s) | set_vec_s;
        pending_nxt_s[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Architectural register file, written from the writeback port
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= '0;
            end
        end else if (wb_valid_i && (wb_rd_i != 5'd0)) begin
            rf_r[wb_rd_i] <= wb_data_i;
        end
    end

    // Issue register: flush drops, accept loads, consume empties, otherwise hold
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            alu_valid_r   <= 1'b0;
            alu_pc_r      <= '0;
            alu_instr_r   <= 32'd0;
            alu_data_a_r  <= '0;
            alu_data_b_r  <= '0;
            alu_rd_r      <= 5'd0;
            alu_wb_en_r   <= 1'b0;
            alu_illegal_r <= 1'b0;
        end else if (flush_i) begin
            alu_valid_r <= 1'b0;
        end else if (accept_s) begin
            alu_valid_r   <= 1'b1;
            alu_pc_r      <= fetch_pc_i;
            alu_instr_r   <= fetch_instr_i;
            alu_data_a_r  <= data_a_s;
            alu_data_b_r  <= data_b_s;
            alu_rd_r      <= rd_s;
            alu_wb_en_r   <= wb_en_s;
            alu_illegal_r <= illegal_s;
        end else if (alu_ready_i) begin
            alu_valid_r <= 1'b0;
        end
    end

    assign fetch_ready_o = fetch_ready_s;
    assign alu_valid_o   = alu_valid_r;
    assign alu_pc_o      = alu_pc_r;
    assign alu_instr_o   = alu_instr_r;
    assign alu_data_a_o  = alu_data_a_r;
    assign alu_data_b_o  = alu_data_b_r;
    assign alu_rd_o      = alu_rd_r;
    assign alu_wb_en_o   = alu_wb_en_r;
    assign alu_illegal_o = alu_illegal_r;

    decode_issue_chk #(.NREGS(NREGS)) u_chk (
        .clk         (clk_i),
        .rst         (rsn_i),
        .pending     (pending_r),
        .fetch_ready (fetch_ready_s),
        .alu_valid   (alu_valid_r),
        .alu_rd      (alu_rd_r),
        .alu_wb_en   (alu_wb_en_r),
        .alu_illegal (alu_illegal_r)
    );

endmodule

// decode_issue_chk: structural invariants of the issue stage.
module decode_issue_chk #(
    parameter int NREGS = 32
) (
    input logic             clk,
    input logic             rst,
    input logic [NREGS-1:0] pending,
    input logic             fetch_ready,
    input logic             alu_valid,
    input logic [4:0]       alu_rd,
    input logic             alu_wb_en,
    input logic             alu_illegal
);

    // Invariants sampled on every rising edge
    always @(posedge clk) begin
        assert (!(rst && fetch_ready)) else $error("decode_issue: ready asserted in reset");
        if (!rst) begin
            assert (!pending[0]) else $error("decode_issue: x0 marked pending");
            assert (!(alu_illegal && alu_wb_en)) else $error("decode_issue: illegal op writes rd");
            assert (!(alu_valid && alu_wb_en && (alu_rd == 5'd0)))
                else $error("decode_issue: write enable on x0");
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed scenarios then random traffic,
// all checked against a cycle-level behavioural model of the stage.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rsn;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic        alu_valid;
    logic        alu_ready;
    logic [31:0] alu_pc;
    logic [31:0] alu_instr;
    logic [31:0] alu_data_a;
    logic [31:0] alu_data_b;
    logic [4:0]  alu_rd;
    logic        alu_wb_en;
    logic        alu_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk_i         (clk),
        .rsn_i         (rsn),
        .fetch_valid_i (fetch_valid),
        .fetch_pc_i    (fetch_pc),
        .fetch_instr_i (fetch_instr),
        .fetch_ready_o (fetch_ready),
        .alu_valid_o   (alu_valid),
        .alu_ready_i   (alu_ready),
        .alu_pc_o      (alu_pc),
        .alu_instr_o   (alu_instr),
        .alu_data_a_o  (alu_data_a),
        .alu_data_b_o  (alu_data_b),
        .alu_rd_o      (alu_rd),
        .alu_wb_en_o   (alu_wb_en),
        .alu_illegal_o (alu_illegal),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .wb_data_i     (wb_data),
        .flush_i       (flush)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_valid;
    bit          m_wben;
    bit          m_ill;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_rd;
    bit          last_ready;

    function automatic bit uses1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011};
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit writes(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111};
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] r, input bit wv,
                                          input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (wv && wr == r) return wd;
        return m_regs[r];
    endfunction

    function automatic bit mbusy(input logic [4:0] r, input bit wv, input logic [4:0] wr);
        return m_pend[r] && !(wv && wr == r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_valid = 1'b0; m_wben = 1'b0; m_ill = 1'b0;
        m_pc = 32'd0; m_instr = 32'd0; m_a = 32'd0; m_b = 32'd0; m_rd = 5'd0;
    endtask

    // One clock: drive inputs, check ready, advance model, check the issue register
    task automatic step(input bit r, input bit fv, input logic [31:0] ins, input bit ar,
                        input bit wv, input logic [4:0] wr, input logic [31:0] wd, input bit fl);
        logic [6:0]  op;
        logic [4:0]  s1, s2, d;
        logic [31:0] pc, va, vb;
        bit          u1, u2, w, haz, rdy, acc;
        pc = $urandom();
        rsn = r; fetch_valid = fv; fetch_pc = pc; fetch_instr = ins; alu_ready = ar;
        wb_valid = wv; wb_rd = wr; wb_data = wd; flush = fl;
        #1;
        op = ins[6:0]; s1 = ins[19:15]; s2 = ins[24:20]; d = ins[11:7];
        u1 = uses1(op); u2 = uses2(op); w = writes(op);
        haz = (u1 && mbusy(s1, wv, wr)) || (u2 && mbusy(s2, wv, wr)) || (w && mbusy(d, wv, wr));
        rdy = !r && (!m_valid || ar) && !haz && !fl;
        check("fetch_ready", 32'(fetch_ready), 32'(rdy));
        last_ready = fetch_ready;
        if (r) begin
            model_reset();
        end else begin
            acc = fv && rdy;
            va  = u1 ? mread(s1, wv, wr, wd) : 32'd0;
            vb  = u2 ? mread(s2, wv, wr, wd) : 32'd0;
            if (wv && wr != 5'd0) begin
                m_regs[wr] = wd;
                m_pend[wr] = 1'b0;
            end
            if (fl && m_valid && m_wben) m_pend[m_rd] = 1'b0;
            if (acc && w && d != 5'd0) m_pend[d] = 1'b1;
            if (fl) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1; m_pc = pc; m_instr = ins; m_a = va; m_b = vb; m_rd = d;
                m_wben = w && d != 5'd0; m_ill = !(u1 || u2 || w);
            end else if (ar) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("alu_valid", 32'(alu_valid), 32'(m_valid));
        if (m_valid) begin
            check("alu_pc", alu_pc, m_pc);
            check("alu_instr", alu_instr, m_instr);
            check("alu_data_a", alu_data_a, m_a);
            check("alu_data_b", alu_data_b, m_b);
            check("alu_rd", 32'(alu_rd), 32'(m_rd));
            check("alu_wb_en", 32'(alu_wb_en), 32'(m_wben));
            check("alu_illegal", 32'(alu_illegal), 32'(m_ill));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] ins;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1110011, 7'b1101111, 7'b1111111, 7'b0110111};
        ins = $urandom();
        ins[6:0]   = ops[$urandom_range(0, 8)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        model_reset();
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'h00100093, 1'b1, 1'b1, 5'd1, 32'h5, 1'b0);
        check("rst_valid", 32'(alu_valid), 32'd0);
        check("rst_pc", alu_pc, 32'd0);
        check("rst_instr", alu_instr, 32'd0);
        check("rst_a", alu_data_a, 32'd0);
        check("rst_b", alu_data_b, 32'd0);
        check("rst_rd", 32'(alu_rd), 32'd0);
        check("rst_wb_en", 32'(alu_wb_en), 32'd0);
        check("rst_illegal", 32'(alu_illegal), 32'd0);

        // writeback x5 then add x6,x5,x0
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 5'd5, 32'h1234, 1'b0);
        step(1'b0, 1'b1, 32'h00028333, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        check("add_a", alu_data_a, 32'h1234);
        check("add_b", alu_data_b, 32'd0);
        check("add_rd", 32'(alu_rd), 32'd6);
        check("add_wb_en", 32'(alu_wb_en), 32'd1);

        // RAW: addi x7,x0,5 then add x8,x7,x7 stalls until wb x7
        step(1'b0, 1'b1, 32'h00500393, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 32'h00738433, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
            check("raw_stall", 32'(last_ready), 32'd0);
        end
        step(1'b0, 1'b1, 32'h00738433, 1'b1, 1'b1, 5'd7, 32'd5, 1'b0);
        check("raw_release", 32'(last_ready), 32'd1);
        check("raw_a", alu_data_a, 32'd5);
        check("raw_b", alu_data_b, 32'd5);

        // back-pressure for three cycles, then release
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h00100513, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            check("bp_ready", 32'(last_ready), 32'd0);
            check("bp_instr", alu_instr, 32'h00738433);
            check("bp_a", alu_data_a, 32'd5);
        end
        step(1'b0, 1'b1, 32'h00100513, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        check("bp_release", alu_instr, 32'h00100513);

        // WAW on x9, flushed away, then re-issued; then a pure WAW stall
        step(1'b0, 1'b1, 32'h00100493, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h00200493, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("waw_hold", 32'(last_ready), 32'd0);
        step(1'b0, 1'b1, 32'h00200493, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        check("flush_valid", 32'(alu_valid), 32'd0);
        step(1'b0, 1'b1, 32'h00200493, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("after_flush_ready", 32'(last_ready), 32'd1);
        check("after_flush_instr", alu_instr, 32'h00200493);
        step(1'b0, 1'b1, 32'h00300493, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        check("waw_stall", 32'(last_ready), 32'd0);

        // x0 destination, illegal opcode, writeback to x0
        step(1'b0, 1'b1, 32'h00100013, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        check("x0_wb_en", 32'(alu_wb_en), 32'd0);
        step(1'b0, 1'b1, 32'h0072807F, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        check("ill_flag", 32'(alu_illegal), 32'd1);
        check("ill_a", alu_data_a, 32'd0);
        check("ill_b", alu_data_b, 32'd0);
        check("ill_wb_en", 32'(alu_wb_en), 32'd0);
        step(1'b0, 1'b1, 32'h000006B3, 1'b1, 1'b1, 5'd0, 32'h0000FFFF, 1'b0);
        check("x0_bypass", alu_data_a, 32'd0);
        step(1'b0, 1'b1, 32'h000007B3, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        check("x0_read", alu_data_a, 32'd0);

        // reset while x3 is pending and an instruction is held
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 5'd3, 32'hABCD, 1'b0);
        step(1'b0, 1'b1, 32'h00700193, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("midrst_valid", 32'(alu_valid), 32'd0);
        step(1'b0, 1'b1, 32'h00018733, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        check("midrst_ready", 32'(last_ready), 32'd1);
        check("midrst_x3", alu_data_a, 32'd0);

        // random traffic on a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, rand_instr(),
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 45,
                 5'($urandom_range(0, 7)), $urandom(), $urandom_range(0, 99) < 5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode/issue stage sitting directly upstream of the integer ALU. Accepts fetched instructions over a valid/ready handshake, reads operands from a 32x32 register file, and holds one decoded instruction in an output register presented to the ALU. Also takes the writeback port, with write-to-read bypass. A per-register scoreboard stalls issue on RAW/WAW hazards against in-flight writes.

## Interface
- XLEN, 32, data/pc width
- NREGS, 32, architectural registers (x0 hardwired zero)
- clk_i  in  1  clock, all state on rising edge
- rsn_i  in  1  reset: synchronous, active-high
- fetch_valid_i  in  1  fetch offers instruction
- fetch_pc_i  in  XLEN  pc of offered instruction
- fetch_instr_i  in  32  offered instruction word
- fetch_ready_o  out  1  stage accepts this cycle (combinational)
- alu_valid_o  out  1  output register holds an instruction
- alu_ready_i  in  1  ALU consumes output this cycle
- alu_pc_o  out  XLEN  registered pc
- alu_instr_o  out  32  registered instruction word
- alu_data_a_o  out  XLEN  rs1 value
- alu_data_b_o  out  XLEN  rs2 value (0 when rs2 unused)
- alu_rd_o  out  5  destination register
- alu_wb_en_o  out  1  instruction writes rd
- alu_illegal_o  out  1  opcode not in supported set
- wb_valid_i  in  1  writeback strobe
- wb_rd_i  in  5  writeback register
- wb_data_i  in  XLEN  writeback value
- flush_i  in  1  discard held output instruction

## Operation
- Opcode = instr[6:0]; rs1 = [19:15], rs2 = [24:20], rd = [11:7].
- Uses rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1110011.
- Uses rs2: 0110011, 0100011, 1100011.
- Writes rd (wb_en=1 iff rd!=0): 0110011, 0010011, 0000011, 1101111.
- Any other opcode: illegal=1, wb_en=0, data_a=data_b=0; still issued.
- Operand read: x0 reads 0. If wb_valid_i && wb_rd_i==rs && rs!=0 the same cycle, use wb_data_i (bypass).
- Register file write: on wb_valid_i && wb_rd_i!=0.
- Scoreboard pending[31:0], pending[0] always 0.
  - A reg is busy when pending[r] && !(wb_valid_i && wb_rd_i==r).
- hazard = (uses_rs1 && busy(rs1)) || (uses_rs2 && busy(rs2)) || (writes_rd && busy(rd)). The rd term is the WAW stall.
- fetch_ready_o = (!alu_valid_o || alu_ready_i) && !hazard && !flush_i.
- Accept = fetch_valid_i && fetch_ready_o.
  - Loads the output register, alu_valid_o=1.
  - Sets pending[rd] if wb_en.
- Output register held while alu_valid_o && !alu_ready_i; all alu_* outputs stable.
- ALU consumes without a new accept: alu_valid_o -> 0.
- Pending update per bit:
  - set on accept-with-wb_en to r;
  - else clear on wb_valid_i to r, or on flush_i of a held instr with wb_en to r.
  - Set wins over a simultaneous clear.
- flush_i: alu_valid_o -> 0, no accept that cycle, held instr's pending bit cleared. Flush with alu_valid_o=0 is a no-op.

## Timing
- Reset (rsn_i=1 at edge) clears:
  - all registers, register file and pending;
  - alu_valid_o, alu_pc_o, alu_instr_o, alu_data_a_o, alu_data_b_o, alu_rd_o, alu_wb_en_o, alu_illegal_o, all to 0.
- fetch_ready_o is 0 during reset cycles. Reset mid-stall drops the held instruction.
- Latency: accept at edge N -> alu_* valid from edge N (registered). Back-to-back throughput: 1/cycle with alu_ready_i=1 and no hazards.
- Hazard stall: fetch_ready_o low until the cycle wb_valid_i hits the busy reg. Accept occurs that same cycle via bypass: zero-bubble release.
- Writeback to x0 ignored: no register file write, no pending effect.
- fetch_ready_o depends combinationally on fetch_instr_i, wb_*, alu_ready_i, flush_i. fetch_valid_i must not depend on fetch_ready_o.

## Test plan
- Reset, then wb x5=0x1234; issue add x6,x5,x0 (0x00028333) with alu_ready_i=1 -> next cycle alu_data_a_o=0x1234, alu_data_b_o=0, alu_rd_o=6, alu_wb_en_o=1.
- RAW stall:
  - Issue addi x7,x0,5 (0x00500393), then add x8,x7,x7 -> fetch_ready_o=0 until wb x7=5.
  - In the wb cycle the add is accepted; data_a=data_b=5 via bypass.
- Back-pressure: alu_ready_i=0 for 3 cycles with fetch_valid_i=1 -> fetch_ready_o=0, alu_* unchanged. Release -> next instr in the following cycle.
- WAW plus flush:
  - Issue addi x9 (pending[9]=1); a second addi x9 stalls.
  - Assert flush_i -> alu_valid_o=0, pending[9]=0.
  - Second addi x9 is accepted the next cycle.
- x0/illegal:
  - addi x0,x0,1 -> alu_wb_en_o=0 and no pending.
  - Opcode 0x7F -> alu_illegal_o=1, data_a=data_b=0.
  - wb to x0 with 0xFFFF -> x0 still reads 0.
- Reset mid-operation: pending x3 and held instr, assert rsn_i one cycle -> alu_valid_o=0, pending cleared, read x3=0.
